// File: rtl/piso_tx_serializer_pkg.sv
// Shared types and helpers for the negedge PISO serializer.
// Defining PIS_PARITY_EN enables the even-parity bit in dependent files.
package piso_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    // Counter width able to hold 0..width.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    // Even parity: 1 when the word holds an odd number of ones.
    function automatic logic even_parity(input logic [31:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/piso_tx_serializer.sv
// Parallel-in serial-out transmitter on falling-edge flops with valid/ready intake.
// Optional feature macro: PIS_PARITY_EN appends an even-parity bit to every frame.
module piso_tx_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             CE,
    input  logic [WIDTH-1:0] TX_DATA,
    input  logic             TX_VALID,
    output logic             TX_READY,
    output logic             SDO,
    output logic             SFRAME,
    output logic             BUSY
);

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    count;
    logic             accept;
    logic             first_bit;
    logic [WIDTH-1:0] load_shreg;
    logic             next_bit;
    logic [WIDTH-1:0] shifted;
`ifdef PIS_PARITY_EN
    logic             par;
`endif

    // Bit ordering: shreg holds the bits still to be sent, next one at the output end.
    always_comb begin
        first_bit  = 1'b0;
        load_shreg = '0;
        next_bit   = 1'b0;
        shifted    = '0;
        if (MSB_FIRST) begin
            first_bit  = TX_DATA[WIDTH-1];
            load_shreg = TX_DATA << 1;
            next_bit   = shreg[WIDTH-1];
            shifted    = shreg << 1;
        end else begin
            first_bit  = TX_DATA[0];
            load_shreg = TX_DATA >> 1;
            next_bit   = shreg[0];
            shifted    = shreg >> 1;
        end
    end

    // Ready in idle and during the final bit cycle so frames can abut.
    always_comb begin
        TX_READY = 1'b0;
        case (state)
            IDLE:    TX_READY = 1'b1;
`ifdef PIS_PARITY_EN
            SHIFT:   TX_READY = 1'b0;
`else
            SHIFT:   TX_READY = (count == LAST);
`endif
            PARITY:  TX_READY = 1'b1;
            default: TX_READY = 1'b0;
        endcase
    end

    assign accept = CE & TX_VALID & TX_READY;

    // Frame FSM, shift register and registered serial outputs.
    always_ff @(negedge CLK or posedge RESET) begin
        if (RESET) begin
            state  <= IDLE;
            shreg  <= '0;
            count  <= '0;
            SDO    <= 1'b0;
            SFRAME <= 1'b0;
            BUSY   <= 1'b0;
`ifdef PIS_PARITY_EN
            par    <= 1'b0;
`endif
        end else if (CE) begin
            if (accept) begin
                state  <= SHIFT;
                shreg  <= load_shreg;
                count  <= '0;
                SDO    <= first_bit;
                SFRAME <= 1'b1;
                BUSY   <= 1'b1;
`ifdef PIS_PARITY_EN
                par    <= even_parity(32'(TX_DATA));
`endif
            end else begin
                case (state)
                    IDLE: begin
                        SDO    <= 1'b0;
                        SFRAME <= 1'b0;
                        BUSY   <= 1'b0;
                    end
                    SHIFT: begin
                        if (count != LAST) begin
                            shreg <= shifted;
                            count <= count + CW'(1);
                            SDO   <= next_bit;
                        end else begin
`ifdef PIS_PARITY_EN
                            state <= PARITY;
                            count <= count + CW'(1);
                            SDO   <= par;
`else
                            state  <= IDLE;
                            shreg  <= '0;
                            count  <= '0;
                            SDO    <= 1'b0;
                            SFRAME <= 1'b0;
                            BUSY   <= 1'b0;
`endif
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        shreg  <= '0;
                        count  <= '0;
                        SDO    <= 1'b0;
                        SFRAME <= 1'b0;
                        BUSY   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_piso_tx_serializer.sv
// Self-checking bench for piso_tx_serializer: directed cases plus random traffic vs a queue model.
// Honours PIS_PARITY_EN the same way as the design.
module tb_piso_tx_serializer;

    localparam int WIDTH     = 8;
    localparam bit MSB_FIRST = 1'b0;
`ifdef PIS_PARITY_EN
    localparam int FLEN = WIDTH + 1;
`else
    localparam int FLEN = WIDTH;
`endif

    typedef bit bitq_t[$];

    logic             CLK;
    logic             RESET;
    logic             CE;
    logic [WIDTH-1:0] TX_DATA;
    logic             TX_VALID;
    logic             TX_READY;
    logic             SDO;
    logic             SFRAME;
    logic             BUSY;

    int    n_checks;
    int    n_fail;
    bitq_t exp_q;

    piso_tx_serializer #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) dut (
        .CLK(CLK), .RESET(RESET), .CE(CE), .TX_DATA(TX_DATA), .TX_VALID(TX_VALID),
        .TX_READY(TX_READY), .SDO(SDO), .SFRAME(SFRAME), .BUSY(BUSY)
    );

    initial CLK = 1'b1;
    always #5 CLK = ~CLK;

    // Bits of one frame in wire order: data bits, then optional even parity.
    function automatic bitq_t frame_bits(input logic [WIDTH-1:0] d);
        bitq_t q;
        for (int i = 0; i < WIDTH; i++)
            q.push_back(MSB_FIRST ? d[WIDTH-1-i] : d[i]);
`ifdef PIS_PARITY_EN
        q.push_back(^d);
`endif
        return q;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_sdo"},    32'(SDO),    32'(exp_q.size() != 0 ? exp_q[0] : 1'b0));
        check({tag, "_sframe"}, 32'(SFRAME), 32'(exp_q.size() != 0));
        check({tag, "_busy"},   32'(BUSY),   32'(exp_q.size() != 0));
    endtask

    // One clock: drive inputs after a rising edge, let the falling edge act, check at next rising edge.
    task automatic step(input logic ce, input logic valid, input logic [WIDTH-1:0] data,
                        output logic acc);
        CE       = ce;
        TX_VALID = valid;
        TX_DATA  = data;
        #1;
        check("ready", 32'(TX_READY), 32'(exp_q.size() <= 1));
        @(negedge CLK);
        acc = 1'b0;
        if (ce) begin
            if (valid && exp_q.size() <= 1) begin
                exp_q = frame_bits(data);
                acc   = 1'b1;
            end else if (exp_q.size() != 0) begin
                void'(exp_q.pop_front());
            end
        end
        @(posedge CLK);
        check_outputs("step");
    endtask

    initial begin
        logic             acc;
        logic [WIDTH-1:0] got;
        int               run;
        int               nacc;

        n_checks = 0;
        n_fail   = 0;
        RESET    = 1'b1;
        CE       = 1'b0;
        TX_VALID = 1'b0;
        TX_DATA  = '0;

        // Reset held two cycles, then idle with TX_VALID low.
        repeat (2) begin
            @(posedge CLK);
            check("rst_sdo", 32'(SDO), 32'd0);
            check("rst_sframe", 32'(SFRAME), 32'd0);
            check("rst_busy", 32'(BUSY), 32'd0);
            check("rst_ready", 32'(TX_READY), 32'd1);
        end
        RESET = 1'b0;
        repeat (3) step(1'b1, 1'b0, '0, acc);

        // Single word 8'hA5: collect the serial bits and measure the frame length.
        step(1'b1, 1'b1, 8'hA5, acc);
        check("a5_accept", 32'(acc), 32'd1);
        got    = '0;
        got[0] = SDO;
        run    = 1;
        for (int i = 1; i < FLEN + 3; i++) begin
            step(1'b1, 1'b0, 8'h00, acc);
            if (i < WIDTH) got[i] = SDO;
            run += int'(SFRAME);
        end
        check("a5_seq", 32'(got), 32'h0000_00A5);
        check("a5_len", 32'(run), 32'(FLEN));

        // Back-to-back 8'h0F then 8'hF0 with TX_VALID held.
        step(1'b1, 1'b1, 8'h0F, acc);
        nacc = 1;
        run  = 1;
        for (int i = 0; i < 2 * FLEN + 1; i++) begin
            step(1'b1, nacc < 2, 8'hF0, acc);
            if (acc) nacc++;
            run += int'(SFRAME);
        end
        check("b2b_accepts", 32'(nacc), 32'd2);
        check("b2b_len", 32'(run), 32'(2 * FLEN));

        // CE gating with 8'h81: no accept while CE low, each bit held two clocks.
        repeat (2) step(1'b0, 1'b1, 8'h81, acc);
        check("ce_no_accept_busy", 32'(BUSY), 32'd0);
        nacc = 0;
        run  = 0;
        for (int i = 0; i < 2 * FLEN + 4; i++) begin
            step(i % 2 == 0, nacc == 0, 8'h81, acc);
            if (acc) nacc++;
            run += int'(SFRAME);
        end
        check("ce_len", 32'(run), 32'(2 * FLEN));

        // Reset mid-frame after three bits of 8'hFF: outputs drop before the next edge.
        step(1'b1, 1'b1, 8'hFF, acc);
        repeat (2) step(1'b1, 1'b0, 8'h00, acc);
        RESET = 1'b1;
        #1;
        exp_q.delete();
        check("midrst_sdo", 32'(SDO), 32'd0);
        check("midrst_sframe", 32'(SFRAME), 32'd0);
        check("midrst_busy", 32'(BUSY), 32'd0);
        check("midrst_ready", 32'(TX_READY), 32'd1);
        repeat (2) @(posedge CLK);
        RESET = 1'b0;
        step(1'b1, 1'b0, 8'h00, acc);

        // Parity-relevant word 8'h07 (plain 8-bit frame when parity is off).
        step(1'b1, 1'b1, 8'h07, acc);
        repeat (FLEN + 1) step(1'b1, 1'b0, 8'h00, acc);

        // Random traffic against the queue model.
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                 WIDTH'($urandom), acc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
